slice_header_sequencer: RTL and testbench

SLICE_HEADER_SEQUENCER -- requirements
Module: slice_header_sequencer

---
 rtl/slice_header_sequencer_pkg.sv | 32 +++
 rtl/slice_header_sequencer_slice_type_normalize.sv | 22 ++
 rtl/slice_header_sequencer.sv | 176 +++++++++++++++++
 tb/tb_slice_header_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_header_sequencer_pkg.sv
// Shared definitions for the slice header sequencer and the external
// dependent-variable decoder that is steered by slice_header_state.
package slice_header_sequencer_pkg;

   // Field-state encoding; the dependent-variable decoder keys off FRAME_NUM_S.
   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      FIRST_MB_S   = 4'd1,
      SLICE_TYPE_S = 4'd2,
      PPS_ID_S     = 4'd3,
      FRAME_NUM_S  = 4'd4,
      IDR_PIC_ID_S = 4'd5,
      DONE_S       = 4'd6,
      ERROR_S      = 4'd7
   } sh_state_e;

   localparam int UE_LEN_MAX  = 17;
   localparam int FRAME_NUM_W = 10;

   // A ue(v) code length is usable only when it lies in 1..UE_LEN_MAX.
   function automatic logic ue_len_ok(input logic [4:0] len);
      return (len != 5'd0) && (len <= 5'(UE_LEN_MAX));
   endfunction

   // frame_num occupies log2_max_frame_num_minus4+4 bits; wider settings
   // saturate at the 10-bit register.
   function automatic logic [FRAME_NUM_W-1:0] frame_num_mask(input logic [3:0] log2_minus4);
      if (log2_minus4 >= 4'd6) return '1;
      return (10'd1 << (log2_minus4 + 4'd4)) - 10'd1;
   endfunction

endpackage

// File: rtl/slice_header_sequencer_slice_type_normalize.sv
// Folds slice_type 5..9 onto 0..4 and flags values outside 0..9.
module slice_type_normalize
   import slice_header_sequencer_pkg::*;
(
   input  logic [7:0] value_i,
   output logic [3:0] slice_type_o,
   output logic       in_range_o
);

   // Pure combinational reduction; every output gets a value on every path.
   always_comb begin
      // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
      slice_type_o = 4'd0;
      in_range_o   = (value_i <= 8'd9);
      if (value_i >= 8'd5 && value_i <= 8'd9) begin
         slice_type_o = value_i[3:0] - 4'd5;
      end else if (value_i <= 8'd4) begin
         slice_type_o = value_i[3:0];
      end
   end

endmodule

// File: rtl/slice_header_sequencer.sv
// Walks the slice header fields one per cycle, consuming bits from the
// bitstream buffer and latching each decoded field.
module slice_header_sequencer
   import slice_header_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start_slice_header,
   input  logic       idr_flag,
   input  logic [3:0] log2_max_frame_num_minus4,
   input  logic       buffer_valid,
   input  logic [4:0] exp_golomb_len,
   input  logic [7:0] exp_golomb_value,
   input  logic [3:0] dependent_variable_len,
   input  logic [9:0] dependent_variable_decoding_output,
   output logic [3:0] slice_header_state,
   output logic       consume_valid,
   output logic [4:0] consume_len,
   output logic [7:0] first_mb_in_slice,
   output logic [3:0] slice_type,
   output logic [7:0] pps_id,
   output logic [9:0] frame_num,
   output logic [7:0] idr_pic_id,
   output logic       header_done,
   output logic       header_error
);

   sh_state_e  state_q, state_d;
   logic       idr_q, idr_d;
   logic [7:0] first_mb_q, first_mb_d;
   logic [3:0] slice_type_q, slice_type_d;
   logic [7:0] pps_id_q, pps_id_d;
   logic [9:0] frame_num_q, frame_num_d;
   logic [7:0] idr_pic_id_q, idr_pic_id_d;
   logic       header_error_q, header_error_d;

   logic       ue_ok;
   logic [3:0] st_norm;
   logic       st_in_range;

   assign ue_ok = ue_len_ok(exp_golomb_len);

   slice_type_normalize u_slice_type_normalize (
      .value_i      (exp_golomb_value),
      .slice_type_o (st_norm),
      .in_range_o   (st_in_range)
   );

   // Next state, field loads and buffer consumption for the current field.
   // The 8-bit fields hold any value the 8-bit ue(v) head can carry, so only
   // slice_type can overflow its field.
   always_comb begin
      state_d        = state_q;
      idr_d          = idr_q;
      first_mb_d     = first_mb_q;
      slice_type_d   = slice_type_q;
      pps_id_d       = pps_id_q;
      frame_num_d    = frame_num_q;
      idr_pic_id_d   = idr_pic_id_q;
      header_error_d = header_error_q;
      consume_valid  = 1'b0;
      consume_len    = 5'd0;

      case (state_q)
         IDLE: begin
            if (start_slice_header) begin
               state_d        = FIRST_MB_S;
               idr_d          = idr_flag;
               header_error_d = 1'b0;
            end
         end
         FIRST_MB_S: begin
            if (buffer_valid) begin
               if (!ue_ok) begin
                  state_d = ERROR_S;
               end else begin
                  consume_valid = 1'b1;
                  consume_len   = exp_golomb_len;
                  first_mb_d    = exp_golomb_value;
                  state_d       = SLICE_TYPE_S;
               end
            end
         end
         SLICE_TYPE_S: begin
            if (buffer_valid) begin
               if (!ue_ok || !st_in_range) begin
                  state_d = ERROR_S;
               end else begin
                  consume_valid = 1'b1;
                  consume_len   = exp_golomb_len;
                  slice_type_d  = st_norm;
                  state_d       = PPS_ID_S;
               end
            end
         end
         PPS_ID_S: begin
            if (buffer_valid) begin
               if (!ue_ok) begin
                  state_d = ERROR_S;
               end else begin
                  consume_valid = 1'b1;
                  consume_len   = exp_golomb_len;
                  pps_id_d      = exp_golomb_value;
                  state_d       = FRAME_NUM_S;
               end
            end
         end
         FRAME_NUM_S: begin
            if (buffer_valid) begin
               consume_valid = 1'b1;
               consume_len   = {1'b0, dependent_variable_len};
               frame_num_d   = dependent_variable_decoding_output
                               & frame_num_mask(log2_max_frame_num_minus4);
               if (idr_q) begin
                  state_d = IDR_PIC_ID_S;
               end else begin
                  idr_pic_id_d = 8'd0;
                  state_d      = DONE_S;
               end
            end
         end
         IDR_PIC_ID_S: begin
            if (buffer_valid) begin
               if (!ue_ok) begin
                  state_d = ERROR_S;
               end else begin
                  consume_valid = 1'b1;
                  consume_len   = exp_golomb_len;
                  idr_pic_id_d  = exp_golomb_value;
                  state_d       = DONE_S;
               end
            end
         end
         DONE_S:  state_d = IDLE;
         ERROR_S: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The error flag rises as ERROR_S is entered so it is visible there.
      if (state_d == ERROR_S) header_error_d = 1'b1;
   end

   // State and field registers; reset aborts any parse in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         idr_q          <= 1'b0;
         first_mb_q     <= 8'd0;
         slice_type_q   <= 4'd0;
         pps_id_q       <= 8'd0;
         frame_num_q    <= 10'd0;
         idr_pic_id_q   <= 8'd0;
         header_error_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q        <= state_d;
         idr_q          <= idr_d;
         first_mb_q     <= first_mb_d;
         slice_type_q   <= slice_type_d;
         pps_id_q       <= pps_id_d;
         frame_num_q    <= frame_num_d;
         idr_pic_id_q   <= idr_pic_id_d;
         header_error_q <= header_error_d;
      end
   end

   assign slice_header_state = state_q;
   assign header_done        = (state_q == DONE_S);
   assign header_error       = header_error_q;
   assign first_mb_in_slice  = first_mb_q;
   assign slice_type         = slice_type_q;
   assign pps_id             = pps_id_q;
   assign frame_num          = frame_num_q;
   assign idr_pic_id         = idr_pic_id_q;

endmodule

// File: tb/tb_slice_header_sequencer.sv
// Directed bench for slice_header_sequencer: reset, non-IDR and IDR parses,
// buffer stalls, slice_type/length errors, mid-parse reset, ignored start.
module tb_slice_header_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start_slice_header;
   logic       idr_flag;
   logic [3:0] log2_max_frame_num_minus4;
   logic       buffer_valid;
   logic [4:0] exp_golomb_len;
   logic [7:0] exp_golomb_value;
   logic [3:0] dependent_variable_len;
   logic [9:0] dependent_variable_decoding_output;
   logic [3:0] slice_header_state;
   logic       consume_valid;
   logic [4:0] consume_len;
   logic [7:0] first_mb_in_slice;
   logic [3:0] slice_type;
   logic [7:0] pps_id;
   logic [9:0] frame_num;
   logic [7:0] idr_pic_id;
   logic       header_done;
   logic       header_error;

   int checks = 0;
   int errors = 0;

   int   cyc;
   int   done_cycle;
   logic saw_idr;
   logic stall_bad;

   always #5 clk = ~clk;

   slice_header_sequencer dut (
      .clk                                (clk),
      .reset_n                            (reset_n),
      .start_slice_header                 (start_slice_header),
      .idr_flag                           (idr_flag),
      .log2_max_frame_num_minus4          (log2_max_frame_num_minus4),
      .buffer_valid                       (buffer_valid),
      .exp_golomb_len                     (exp_golomb_len),
      .exp_golomb_value                   (exp_golomb_value),
      .dependent_variable_len             (dependent_variable_len),
      .dependent_variable_decoding_output (dependent_variable_decoding_output),
      .slice_header_state                 (slice_header_state),
      .consume_valid                      (consume_valid),
      .consume_len                        (consume_len),
      .first_mb_in_slice                  (first_mb_in_slice),
      .slice_type                         (slice_type),
      .pps_id                             (pps_id),
      .frame_num                          (frame_num),
      .idr_pic_id                         (idr_pic_id),
      .header_done                        (header_done),
      .header_error                       (header_error)
   );

   // Length of the ue(v) codeword for v: 2*floor(log2(v+1))+1.
   function automatic logic [4:0] ue_len(input logic [7:0] v);
      int n = 0;
      int x = int'(v) + 1;
      while ((x >> (n + 1)) != 0) n++;
      return 5'(2 * n + 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ue(input logic [7:0] v);
      exp_golomb_value = v;
      exp_golomb_len   = ue_len(v);
   endtask

   // Sample one cycle at the falling edge, then advance to the next cycle.
   task automatic step();
      @(negedge clk);
      if (header_done === 1'b1 && done_cycle == 0) done_cycle = cyc;
      if (slice_header_state === 4'd5) saw_idr = 1'b1;
      if (buffer_valid === 1'b0 && (slice_header_state !== 4'd3 || consume_valid !== 1'b0))
         stall_bad = 1'b1;
      tick();
      cyc++;
   endtask

   // Drive a full header on a fixed schedule; the start cycle is cycle 1.
   task automatic parse(input logic idr, input logic [7:0] fm, input logic [7:0] st,
                        input logic [7:0] pps, input logic [7:0] idrp,
                        input logic [3:0] fl, input logic [9:0] fv,
                        input int stall, input logic poke_start);
      done_cycle = 0; saw_idr = 1'b0; stall_bad = 1'b0; cyc = 1;
      start_slice_header = 1'b1; idr_flag = idr; buffer_valid = 1'b1;
      set_ue(fm);
      step();
      start_slice_header = 1'b0;
      idr_flag = 1'b0;
      step();
      set_ue(st);
      if (poke_start) begin
         start_slice_header = 1'b1;
         idr_flag = 1'b1;
      end
      step();
      start_slice_header = 1'b0;
      idr_flag = 1'b0;
      set_ue(pps);
      buffer_valid = 1'b0;
      repeat (stall) step();
      buffer_valid = 1'b1;
      step();
      dependent_variable_len = fl;
      dependent_variable_decoding_output = fv;
      exp_golomb_len = 5'd0;
      step();
      if (idr) begin
         set_ue(idrp);
         step();
      end
      for (int i = 0; i < 12 && done_cycle == 0; i++) step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start_slice_header = 1'b0; idr_flag = 1'b0; log2_max_frame_num_minus4 = 4'd2;
      buffer_valid = 1'b1; exp_golomb_len = 5'd5; exp_golomb_value = 8'd9;
      dependent_variable_len = 4'd6; dependent_variable_decoding_output = 10'h2A;
      #12;
      checks++; if (slice_header_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", slice_header_state); end
      checks++; if (consume_valid !== 1'b0 || consume_len !== 5'd0) begin errors++; $display("FAIL reset_consume got %0b/%0d want 0/0", consume_valid, consume_len); end
      checks++; if (header_done !== 1'b0 || header_error !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b/%0b want 0/0", header_done, header_error); end
      checks++; if ({first_mb_in_slice, slice_type, pps_id, frame_num, idr_pic_id} !== '0) begin errors++; $display("FAIL reset_fields got nonzero want 0"); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_idr();
      parse(1'b1, 8'd10, 8'd9, 8'd4, 8'd3, 4'd6, 10'd21, 0, 1'b0);
      checks++; if (done_cycle !== 7) begin errors++; $display("FAIL idr_latency got %0d want 7", done_cycle); end
      checks++; if (saw_idr !== 1'b1) begin errors++; $display("FAIL idr_visit got %0b want 1", saw_idr); end
      checks++; if (idr_pic_id !== 8'd3) begin errors++; $display("FAIL idr_pic_id got %0d want 3", idr_pic_id); end
      checks++; if (slice_type !== 4'd4 || frame_num !== 10'd21 || first_mb_in_slice !== 8'd10 || pps_id !== 8'd4) begin
         errors++; $display("FAIL idr_fields got st=%0d fn=%0d fm=%0d pps=%0d want 4/21/10/4", slice_type, frame_num, first_mb_in_slice, pps_id);
      end
   endtask

   task automatic test_non_idr();
      start_slice_header = 1'b1; idr_flag = 1'b0; buffer_valid = 1'b1;
      log2_max_frame_num_minus4 = 4'd2;
      set_ue(8'd0);
      @(negedge clk);
      checks++; if (slice_header_state !== 4'd0) begin errors++; $display("FAIL nidr_c1_state got %0d want 0", slice_header_state); end
      tick(); start_slice_header = 1'b0;
      @(negedge clk);
      checks++; if (slice_header_state !== 4'd1 || consume_valid !== 1'b1 || consume_len !== 5'd1) begin
         errors++; $display("FAIL nidr_c2 got st=%0d cv=%0b len=%0d want 1/1/1", slice_header_state, consume_valid, consume_len);
      end
      tick(); set_ue(8'd7);
      @(negedge clk);
      checks++; if (slice_header_state !== 4'd2 || consume_len !== 5'd7) begin errors++; $display("FAIL nidr_c3 got st=%0d len=%0d want 2/7", slice_header_state, consume_len); end
      tick(); set_ue(8'd1);
      @(negedge clk);
      checks++; if (slice_header_state !== 4'd3 || consume_len !== 5'd3) begin errors++; $display("FAIL nidr_c4 got st=%0d len=%0d want 3/3", slice_header_state, consume_len); end
      tick();
      exp_golomb_len = 5'd0; dependent_variable_len = 4'd6; dependent_variable_decoding_output = 10'h2A;
      @(negedge clk);
      checks++; if (slice_header_state !== 4'd4 || consume_valid !== 1'b1 || consume_len !== 5'd6 || header_done !== 1'b0) begin
         errors++; $display("FAIL nidr_c5 got st=%0d cv=%0b len=%0d done=%0b want 4/1/6/0", slice_header_state, consume_valid, consume_len, header_done);
      end
      tick();
      @(negedge clk);
      checks++; if (header_done !== 1'b1 || slice_header_state !== 4'd6 || consume_valid !== 1'b0) begin
         errors++; $display("FAIL nidr_c6_done got done=%0b st=%0d cv=%0b want 1/6/0", header_done, slice_header_state, consume_valid);
      end
      checks++; if (slice_type !== 4'd2 || frame_num !== 10'd42 || idr_pic_id !== 8'd0) begin
         errors++; $display("FAIL nidr_fields got st=%0d fn=%0d idr=%0d want 2/42/0", slice_type, frame_num, idr_pic_id);
      end
      checks++; if (first_mb_in_slice !== 8'd0 || pps_id !== 8'd1) begin errors++; $display("FAIL nidr_ue_fields got fm=%0d pps=%0d want 0/1", first_mb_in_slice, pps_id); end
      tick();
      @(negedge clk);
      checks++; if (header_done !== 1'b0 || slice_header_state !== 4'd0) begin errors++; $display("FAIL nidr_c7 got done=%0b st=%0d want 0/0", header_done, slice_header_state); end
      tick();
   endtask

   task automatic test_stall();
      parse(1'b0, 8'd2, 8'd3, 8'd7, 8'd0, 4'd6, 10'h3F, 4, 1'b0);
      checks++; if (done_cycle !== 10) begin errors++; $display("FAIL stall_latency got %0d want 10", done_cycle); end
      checks++; if (stall_bad !== 1'b0) begin errors++; $display("FAIL stall_hold got %0b want 0", stall_bad); end
      checks++; if (pps_id !== 8'd7 || slice_type !== 4'd3 || frame_num !== 10'd63) begin
         errors++; $display("FAIL stall_fields got pps=%0d st=%0d fn=%0d want 7/3/63", pps_id, slice_type, frame_num);
      end
   endtask

   task automatic test_error();
      start_slice_header = 1'b1; idr_flag = 1'b0; buffer_valid = 1'b1; set_ue(8'd4);
      tick(); start_slice_header = 1'b0;
      tick(); set_ue(8'd12);
      tick();
      @(negedge clk);
      checks++; if (slice_header_state !== 4'd7 || header_error !== 1'b1 || consume_valid !== 1'b0) begin
         errors++; $display("FAIL err_st got st=%0d err=%0b cv=%0b want 7/1/0", slice_header_state, header_error, consume_valid);
      end
      tick();
      @(negedge clk);
      checks++; if (slice_header_state !== 4'd0 || header_error !== 1'b1) begin errors++; $display("FAIL err_idle got st=%0d err=%0b want 0/1", slice_header_state, header_error); end
      tick(); start_slice_header = 1'b1; exp_golomb_len = 5'd18; exp_golomb_value = 8'd0;
      tick(); start_slice_header = 1'b0;
      @(negedge clk);
      checks++; if (header_error !== 1'b0 || slice_header_state !== 4'd1 || consume_valid !== 1'b0) begin
         errors++; $display("FAIL err_clear got err=%0b st=%0d cv=%0b want 0/1/0", header_error, slice_header_state, consume_valid);
      end
      tick();
      @(negedge clk);
      checks++; if (slice_header_state !== 4'd7 || header_error !== 1'b1) begin errors++; $display("FAIL err_len got st=%0d err=%0b want 7/1", slice_header_state, header_error); end
      for (int i = 0; i < 10 && slice_header_state !== 4'd0; i++) tick();
      checks++; if (slice_header_state !== 4'd0) begin errors++; $display("FAIL err_return got st=%0d want 0", slice_header_state); end
      tick();
   endtask

   task automatic test_reset_mid();
      start_slice_header = 1'b1; idr_flag = 1'b0; buffer_valid = 1'b1; set_ue(8'd5);
      tick(); start_slice_header = 1'b0;
      tick(); set_ue(8'd3);
      tick(); set_ue(8'd2);
      tick(); dependent_variable_len = 4'd6; dependent_variable_decoding_output = 10'h11;
      #2;
      checks++; if (slice_header_state !== 4'd4 || consume_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got st=%0d cv=%0b want 4/1", slice_header_state, consume_valid); end
      reset_n = 1'b0;
      #1;
      checks++; if (slice_header_state !== 4'd0 || consume_valid !== 1'b0 || consume_len !== 5'd0) begin
         errors++; $display("FAIL rmid_async got st=%0d cv=%0b len=%0d want 0/0/0", slice_header_state, consume_valid, consume_len);
      end
      checks++; if ({first_mb_in_slice, slice_type, pps_id, frame_num, idr_pic_id, header_done, header_error} !== '0) begin
         errors++; $display("FAIL rmid_fields got fm=%0d st=%0d pps=%0d want 0/0/0", first_mb_in_slice, slice_type, pps_id);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick();
      parse(1'b0, 8'd9, 8'd0, 8'd3, 8'd0, 4'd6, 10'h2A, 0, 1'b0);
      checks++; if (done_cycle !== 6 || first_mb_in_slice !== 8'd9 || frame_num !== 10'd42 || pps_id !== 8'd3) begin
         errors++; $display("FAIL rmid_fresh got done=%0d fm=%0d fn=%0d pps=%0d want 6/9/42/3", done_cycle, first_mb_in_slice, frame_num, pps_id);
      end
   endtask

   task automatic test_ignored_start();
      parse(1'b0, 8'd1, 8'd6, 8'd0, 8'd0, 4'd6, 10'd5, 0, 1'b1);
      checks++; if (done_cycle !== 6 || saw_idr !== 1'b0) begin errors++; $display("FAIL ign_seq got done=%0d idr_seen=%0b want 6/0", done_cycle, saw_idr); end
      checks++; if (slice_type !== 4'd1 || first_mb_in_slice !== 8'd1 || frame_num !== 10'd5 || idr_pic_id !== 8'd0) begin
         errors++; $display("FAIL ign_fields got st=%0d fm=%0d fn=%0d idr=%0d want 1/1/5/0", slice_type, first_mb_in_slice, frame_num, idr_pic_id);
      end
   endtask

   initial begin
      test_reset();
      test_idr();
      test_non_idr();
      test_stall();
      test_error();
      test_reset_mid();
      test_ignored_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
